wb_pwm_dt: RTL and testbench

//  Wishbone slave PWM generator with complementary outputs and dead-time insertion.

---
 rtl/wb_pwm_dt_if.sv | 22 ++
 rtl/wb_pwm_dt.sv | 168 ++++++++++++++++
 tb/tb_wb_pwm_dt.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pwm_dt_if.sv
// Wishbone classic slave bundle for the dead-time PWM block.
// Signal names keep the bus-side _i/_o direction as seen from the slave.
interface wb_pwm_dt_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_pwm_dt.sv
// Wishbone-mapped PWM generator with complementary outputs and dead-time insertion.
// Period/duty are double-buffered and only swap in at the period boundary.
module wb_pwm_dt #(
    parameter int CNT_WIDTH = 16,
    parameter int DT_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    wb_pwm_dt_if.slave wb,
    output logic       intr,
    output logic       pwm_out,
    output logic       pwm_n_out
);
    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_PERIOD = 3'd1;
    localparam logic [2:0] IDX_DUTY   = 3'd2;
    localparam logic [2:0] IDX_DT     = 3'd3;
    localparam logic [2:0] IDX_COUNT  = 3'd4;
    localparam logic [2:0] IDX_STATUS = 3'd5;

    typedef enum logic [1:0] {S_OFF, S_HI, S_LO, S_DEAD} state_t;

    logic                 req, wr_en, ack_q;
    logic [2:0]           idx;
    logic [31:0]          rd_data, dat_q;
    logic [2:0]           ctrl_q;
    logic                 en, inv, irq_en;
    logic [CNT_WIDTH-1:0] per_buf_q, duty_buf_q, per_act_q, duty_act_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0]  dt_q, dt_cnt_q, dt_cnt_d;
    logic                 wrap, wrap_clr, wrap_q, wrap_d;
    logic                 raw_d, raw_q, raw_prev_q;
    state_t               state_q, state_d, target;
    logic                 enter_dead;
    logic                 unused_bus;

    assign req      = wb.wb_stb_i & wb.wb_cyc_i;
    assign idx      = wb.wb_adr_i[4:2];
    assign wr_en    = req & ack_q & wb.wb_we_i;
    assign en       = ctrl_q[0];
    assign inv      = ctrl_q[1];
    assign irq_en   = ctrl_q[2];
    // Byte selects and the upper address bits carry no meaning for this slave.
    assign unused_bus = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

    always_comb begin
        rd_data = '0;
        case (idx)
            IDX_CTRL:   rd_data = {29'd0, ctrl_q};
            IDX_PERIOD: rd_data = 32'(per_buf_q);
            IDX_DUTY:   rd_data = 32'(duty_buf_q);
            IDX_DT:     rd_data = 32'(dt_q);
            IDX_COUNT:  rd_data = 32'(cnt_q);
            IDX_STATUS: rd_data = {31'd0, wrap_q};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req & ~ack_q;
            dat_q <= (req & ~ack_q) ? rd_data : '0;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            per_buf_q  <= '0;
            duty_buf_q <= '0;
            dt_q       <= '0;
        end else if (wr_en) begin
            case (idx)
                IDX_CTRL:   ctrl_q     <= wb.wb_dat_i[2:0];
                IDX_PERIOD: per_buf_q  <= wb.wb_dat_i[CNT_WIDTH-1:0];
                IDX_DUTY:   duty_buf_q <= wb.wb_dat_i[CNT_WIDTH-1:0];
                IDX_DT:     dt_q       <= wb.wb_dat_i[DT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Counter, wrap flag and shadow transfer
    assign wrap     = en & (cnt_q == per_act_q);
    assign cnt_d    = (en & ~wrap) ? cnt_q + 1'b1 : '0;
    assign wrap_clr = wr_en & (idx == IDX_STATUS) & wb.wb_dat_i[0];
    assign wrap_d   = wrap | (wrap_q & ~wrap_clr);
    assign raw_d    = cnt_q < duty_act_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            per_act_q  <= '0;
            duty_act_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            if (~en | wrap) begin
                per_act_q  <= per_buf_q;
                duty_act_q <= duty_buf_q;
            end
        end
    end

    assign intr = wrap_q & irq_en;

    // Stage 1: registered raw compare
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q      <= 1'b0;
            raw_prev_q <= 1'b0;
        end else begin
            raw_q      <= raw_d;
            raw_prev_q <= raw_q;
        end
    end

    // Stage 2: output FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_OFF;
            dt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dt_cnt_d   = dt_cnt_q;
        target     = raw_q ? S_HI : S_LO;
        enter_dead = (state_q == S_OFF) | ((state_q == S_HI) & ~raw_q) |
                     ((state_q == S_LO) & raw_q);
        if (!en) begin
            state_d = S_OFF;
        end else if (state_q == S_DEAD) begin
            // A raw edge while dead restarts the wait, so short pulses are swallowed.
            if (raw_q != raw_prev_q) begin
                if (dt_q == '0) state_d = target;
                else            dt_cnt_d = dt_q;
            end else if (dt_cnt_q <= DT_WIDTH'(1)) begin
                state_d = target;
            end else begin
                dt_cnt_d = dt_cnt_q - 1'b1;
            end
        end else if (enter_dead) begin
            if (dt_q == '0) begin
                state_d = target;
            end else begin
                state_d  = S_DEAD;
                dt_cnt_d = dt_q;
            end
        end
    end

    always_comb begin
        pwm_out   = (state_q == S_HI) ^ inv;
        pwm_n_out = (state_q == S_LO) ^ inv;
    end
endmodule

// File: tb/tb_wb_pwm_dt.sv
// Bench for wb_pwm_dt: directed waveform checks plus randomized bus traffic
// compared cycle by cycle against a run-length based reference model.
module tb_wb_pwm_dt;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic intr, pwm_out, pwm_n_out;
    int   n_cmp = 0;
    int   n_err = 0;

    wb_pwm_dt_if wb();

    wb_pwm_dt #(.CNT_WIDTH(16), .DT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .intr(intr), .pwm_out(pwm_out), .pwm_n_out(pwm_n_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register file, counter arithmetic and raw-level run lengths.
    logic [31:0] m_per_buf, m_per_act, m_duty_buf, m_duty_act, m_cnt, m_dat;
    int          m_dt, m_run;
    bit          m_en, m_inv, m_irq, m_wrap, m_ack, m_rawq, m_hi, m_lo;

    task automatic model_reset();
        m_per_buf = 0; m_per_act = 0; m_duty_buf = 0; m_duty_act = 0; m_cnt = 0; m_dat = 0;
        m_dt = 0; m_run = 0; m_en = 0; m_inv = 0; m_irq = 0; m_wrap = 0; m_ack = 0;
        m_rawq = 0; m_hi = 0; m_lo = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] i);
        case (i)
            3'd0:    return {29'd0, m_irq, m_inv, m_en};
            3'd1:    return m_per_buf;
            3'd2:    return m_duty_buf;
            3'd3:    return 32'(m_dt);
            3'd4:    return m_cnt;
            3'd5:    return {31'd0, m_wrap};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        req, wr, wrap, raw_new;
        logic [2:0]  i;
        logic [31:0] d;
        req = wb.wb_stb_i & wb.wb_cyc_i;
        wr  = req & m_ack & wb.wb_we_i;
        i   = wb.wb_adr_i[4:2];
        d   = wb.wb_dat_i;
        // A side is driven once raw has held its level for more than DEADTIME enabled cycles.
        m_hi = m_en && (m_run > m_dt) && m_rawq;
        m_lo = m_en && (m_run > m_dt) && !m_rawq;
        raw_new = (m_cnt < m_duty_act);
        wrap    = m_en && (m_cnt == m_per_act);
        m_dat   = (req && !m_ack) ? model_read(i) : 32'd0;
        if (!m_en || wrap) begin
            m_per_act  = m_per_buf;
            m_duty_act = m_duty_buf;
        end
        m_cnt  = (m_en && !wrap) ? ((m_cnt + 1) & 32'hFFFF) : 32'd0;
        m_wrap = wrap || (m_wrap && !(wr && i == 3'd5 && d[0]));
        if (wr) begin
            case (i)
                3'd0: begin m_en = d[0]; m_inv = d[1]; m_irq = d[2]; end
                3'd1: m_per_buf  = d & 32'hFFFF;
                3'd2: m_duty_buf = d & 32'hFFFF;
                3'd3: m_dt       = int'(d & 32'hFF);
                default: ;
            endcase
        end
        m_ack = req && !m_ack;
        if (!m_en)                               m_run = 0;
        else if (m_run > 0 && raw_new == m_rawq) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else                                     m_run = 1;
        m_rawq = raw_new;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else      model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("ack", 32'(wb.wb_ack_o), 32'(m_ack));
        chk("dat", wb.wb_dat_o, m_dat);
        chk("intr", 32'(intr), 32'(m_wrap & m_irq));
        chk("pwm", 32'(pwm_out), 32'(m_hi ^ m_inv));
        chk("pwm_n", 32'(pwm_n_out), 32'(m_lo ^ m_inv));
        chk("overlap", 32'((pwm_out ^ m_inv) & (pwm_n_out ^ m_inv)), 32'd0);
    end

    task automatic bus(input bit we, input logic [2:0] i, input logic [31:0] d,
                       output logic [31:0] q);
        int          n;
        logic [31:0] a;
        a = 32'h8000_0000;
        a[4:2] = i;
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = a; wb.wb_dat_i = d; wb.wb_sel_i = 4'($urandom);
        n = 0;
        @(posedge clk); #1;
        while (!wb.wb_ack_o && n < 8) begin @(posedge clk); #1; n++; end
        if (!wb.wb_ack_o) chk("ack_timeout", 32'(wb.wb_ack_o), 32'd1);
        q = wb.wb_dat_o;
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] i, input logic [31:0] d);
        logic [31:0] q;
        bus(1'b1, i, d, q);
    endtask

    task automatic count_pins(input int n, output int hi, output int lo);
        hi = 0; lo = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(pwm_out);
            lo += int'(pwm_n_out);
        end
    endtask

    task automatic settle();
        repeat (30) @(posedge clk);
    endtask

    initial begin
        int          h, l, n;
        logic [31:0] q;
        bit          inv, irq;
        wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
        wb.wb_adr_i = 0; wb.wb_dat_i = 0; wb.wb_sel_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_pwm_n", 32'(pwm_n_out), 32'd0);
        chk("rst_intr", 32'(intr), 32'd0);
        rst = 1'b1;
        bus(1'b0, 3'd4, 32'd0, q);
        chk("rst_count", q, 32'd0);

        wr(3'd1, 32'd9); wr(3'd2, 32'd3); wr(3'd3, 32'd0); wr(3'd0, 32'd1);
        settle(); count_pins(10, h, l);
        chk("t1_hi", 32'(h), 32'd3); chk("t1_lo", 32'(l), 32'd7);

        wr(3'd0, 32'd0); wr(3'd3, 32'd2); wr(3'd0, 32'd1);
        settle(); count_pins(10, h, l);
        chk("t2_hi", 32'(h), 32'd1); chk("t2_lo", 32'(l), 32'd5);

        wr(3'd0, 32'd0); wr(3'd3, 32'd0); wr(3'd2, 32'd0); wr(3'd0, 32'd1);
        settle(); count_pins(20, h, l);
        chk("t4_duty0_hi", 32'(h), 32'd0);
        wr(3'd0, 32'd0); wr(3'd2, 32'd12); wr(3'd0, 32'd1);
        settle(); count_pins(20, h, l);
        chk("t4_full_hi", 32'(h), 32'd20);
        wr(3'd0, 32'd0); wr(3'd3, 32'd5); wr(3'd2, 32'd3); wr(3'd0, 32'd1);
        settle(); count_pins(20, h, l);
        chk("t4_swallow_hi", 32'(h), 32'd0);

        wr(3'd0, 32'd0); wr(3'd3, 32'd0); wr(3'd0, 32'd5);
        n = 0;
        while (!intr && n < 40) begin @(negedge clk); n++; end
        chk("t5_intr_seen", 32'(intr), 32'd1);
        wr(3'd5, 32'd1);
        bus(1'b0, 3'd1, 32'd0, q);
        chk("t5_period_rd", q, 32'd9);

        wr(3'd0, 32'd0); wr(3'd2, 32'd12); wr(3'd0, 32'd1);
        settle();
        @(posedge clk); #1;
        chk("t6_pre", 32'(pwm_out), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_pwm_async", 32'(pwm_out), 32'd0);
        chk("t6_pwm_n_async", 32'(pwm_n_out), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        count_pins(20, h, l);
        chk("t6_idle", 32'(h + l), 32'd0);

        for (int seg = 0; seg < 20; seg++) begin
            inv = 1'($urandom); irq = 1'($urandom);
            wr(3'd0, {30'd0, inv, 1'b0});
            wr(3'd1, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 15));
            wr(3'd2, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 18));
            wr(3'd3, $urandom_range(0, 4));
            wr(3'd0, {29'd0, irq, inv, 1'b1});
            for (int op = 0; op < 40; op++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: repeat ($urandom_range(1, 6)) @(posedge clk);
                    4: bus(1'b0, 3'($urandom_range(0, 7)), $urandom, q);
                    5: wr(3'd1, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 15));
                    6: wr(3'd2, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 18));
                    7: wr(3'd5, 32'($urandom_range(0, 1)));
                    8: wr(3'd0, {29'd0, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0)});
                    default: wr(3'($urandom_range(4, 7)), $urandom);
                endcase
            end
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
